// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out stage feeding a 1-bit shift register chain
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ser_data,
    output logic             o_ser_en,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    // With GAP_CYCLES == 0 the GAP state is unreachable, so the wrapped value is never used.
    localparam logic [7:0] LAST_GAP = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       gap_q, gap_d;
    logic             done_q, done_d;

    logic             last_bit;
    logic             xfer;
    logic [WIDTH-1:0] shreg_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        done_d   = 1'b0;

        last_bit = (state_q == SHIFT) && (cnt_q == LAST_BIT);
        // Accepting on the last bit lets back-to-back words keep the enable continuous.
        o_ready  = (state_q == IDLE) || (last_bit && (GAP_CYCLES == 0));
        xfer     = i_valid && o_ready;

        if (MSB_FIRST) begin
            shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
        end

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    shreg_d = i_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = shreg_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else if (xfer) begin
                        shreg_d = i_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_q == LAST_GAP) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        o_ser_data = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        o_ser_en   = (state_q == SHIFT);
        o_busy     = (state_q != IDLE);
        o_done     = done_q;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for three piso_serializer configurations
module tb_piso_serializer;

    logic       clk;
    logic       rst_n;
    logic [2:0] valid;
    logic [2:0] ready;
    logic [2:0] ser_data;
    logic [2:0] ser_en;
    logic [2:0] busy;
    logic [2:0] done;
    logic [7:0] data [3];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        bit b;
        int cyc;
        bit rdy;
    } exp_t;

    exp_t exp_q  [3][$];
    int   done_q [3][$];

    logic [7:0] sr;

    // dut0: MSB first, no gap; dut1: LSB first, no gap; dut2: MSB first, 3-cycle gap
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[0]), .o_ready(ready[0]),
        .i_data(data[0]), .o_ser_data(ser_data[0]), .o_ser_en(ser_en[0]),
        .o_busy(busy[0]), .o_done(done[0])
    );
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[1]), .o_ready(ready[1]),
        .i_data(data[1]), .o_ser_data(ser_data[1]), .o_ser_en(ser_en[1]),
        .o_busy(busy[1]), .o_done(done[1])
    );
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[2]), .o_ready(ready[2]),
        .i_data(data[2]), .o_ser_data(ser_data[2]), .o_ser_en(ser_en[2]),
        .o_busy(busy[2]), .o_done(done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream 8-deep serial shift register fed by dut0
    always @(posedge clk) if (ser_en[0]) sr <= {sr[6:0], ser_data[0]};

    always @(negedge clk) begin
        exp_t e;
        int   dc;
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (ser_en[i]) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_bit dut%0d cyc=%0d got ser_en=1 required no bit", i, cyc);
                    end else begin
                        e = exp_q[i].pop_front();
                        if (ser_data[i] !== e.b || cyc != e.cyc || ready[i] !== e.rdy || busy[i] !== 1'b1) begin
                            fails++;
                            $display("FAIL serial_bit dut%0d got bit=%b cyc=%0d rdy=%b busy=%b required bit=%b cyc=%0d rdy=%b busy=1",
                                     i, ser_data[i], cyc, ready[i], busy[i], e.b, e.cyc, e.rdy);
                        end
                    end
                end
                if (done[i]) begin
                    checks++;
                    if (done_q[i].size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_done dut%0d cyc=%0d", i, cyc);
                    end else begin
                        dc = done_q[i].pop_front();
                        if (cyc != dc) begin
                            fails++;
                            $display("FAIL done_cycle dut%0d got cyc=%0d required cyc=%0d", i, cyc, dc);
                        end
                    end
                end
            end
        end
    end

    // bits: first-sent bit in bits[7]; acc returns the edge count at which the word was accepted
    task automatic send(input int i, input logic [7:0] d, input logic [7:0] bits,
                        input int nb, input bit with_done, output int acc);
        bit   got;
        exp_t e;
        got = 1'b0;
        acc = -1;
        valid[i] = 1'b1;
        data[i]  = d;
        for (int t = 0; t < 100 && !got; t++) begin
            if (ready[i]) got = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL handshake_timeout dut%0d got ready=0 required ready=1 within 100 cycles", i);
            valid[i] = 1'b0;
        end else begin
            acc = cyc + 1;
            for (int k = 0; k < nb; k++) begin
                e.b   = bits[7-k];
                e.cyc = acc + k;
                e.rdy = (k == 7) && (i != 2);
                exp_q[i].push_back(e);
            end
            if (with_done) done_q[i].push_back(acc + 8);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int pend;
        pend = 1;
        for (int t = 0; t < 60 && pend != 0; t++) begin
            pend = 0;
            for (int i = 0; i < 3; i++) pend += exp_q[i].size() + done_q[i].size();
            if (pend != 0) @(negedge clk);
        end
        checks++;
        if (pend != 0) begin
            fails++;
            $display("FAIL drain got %0d outstanding items required 0", pend);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 3'b000) begin
            fails++;
            $display("FAIL busy_idle got busy=%b required 000", busy);
        end
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got %0h required %0h", name, got, req);
        end
    endtask

    initial begin
        int a0, a1;
        rst_n = 1'b0;
        valid = 3'b000;
        for (int i = 0; i < 3; i++) data[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_ser_en", {5'd0, ser_en}, 8'h00);
        check("reset_ser_data", {5'd0, ser_data}, 8'h00);
        check("reset_busy", {5'd0, busy}, 8'h00);
        check("reset_done", {5'd0, done}, 8'h00);
        check("reset_ready", {5'd0, ready}, 8'h07);
        rst_n = 1'b1;
        @(negedge clk);

        send(0, 8'hA5, 8'b10100101, 8, 1'b1, a0);
        valid[0] = 1'b0;
        drain();

        send(1, 8'hA5, 8'b10100101, 8, 1'b1, a0);
        valid[1] = 1'b0;
        drain();
        send(1, 8'h01, 8'b10000000, 8, 1'b1, a0);
        valid[1] = 1'b0;
        drain();

        send(0, 8'h3C, 8'b00111100, 8, 1'b1, a0);
        send(0, 8'hC3, 8'b11000011, 8, 1'b1, a1);
        valid[0] = 1'b0;
        check("b2b_accept_spacing", 8'(a1 - a0), 8'd8);
        drain();

        send(2, 8'h5A, 8'b01011010, 8, 1'b1, a0);
        send(2, 8'h96, 8'b10010110, 8, 1'b1, a1);
        valid[2] = 1'b0;
        check("gap_accept_spacing", 8'(a1 - a0), 8'd12);
        drain();

        send(0, 8'hFF, 8'b11111111, 3, 1'b0, a0);
        valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_ser_en", {7'd0, ser_en[0]}, 8'h00);
        check("reset_mid_busy", {7'd0, busy[0]}, 8'h00);
        check("reset_mid_queue", 8'(exp_q[0].size()), 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, 8'h81, 8'b10000001, 8, 1'b1, a0);
        valid[0] = 1'b0;
        drain();

        send(0, 8'h80, 8'b10000000, 8, 1'b1, a0);
        valid[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("chain_tap_after_8", {7'd0, sr[7]}, 8'h01);
        send(0, 8'h00, 8'b00000000, 8, 1'b1, a1);
        valid[0] = 1'b0;
        @(negedge clk);
        check("chain_tap_after_9", {7'd0, sr[7]}, 8'h00);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
